// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the fetch/memory bus arbiter.
// The optional watchdog is enabled with the BUS_TIMEOUT_EN macro.
package mips_bus_pkg;

  // Arbiter FSM states, 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_ACC  = 2'd1,
    ST_MEM_ACC = 2'd2
  } state_t;

  // Grant encodings held in the last-grant register
  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  // Default bus-ack watchdog limit in clock cycles
  localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd255;

  // Read data returned to a requester whose access timed out
  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_arbiter_if.sv
// Pipeline-side request/response signals and the external bus command/response
// bundled together. "master" is the arbiter view, "slave" is the environment
// (pipeline stages plus the external memory).
interface bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input  bus_rdata, bus_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready,
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output stall_if, stall_mem, bus_err
  );

  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output bus_rdata, bus_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  stall_if, stall_mem, bus_err
  );
endinterface

// File: rtl/bus_arbiter_watchdog.sv
// Bus-ack watchdog: counts cycles spent in an access state and flags expiry
// once TIMEOUT_CYCLES access cycles have elapsed. Only exists when
// BUS_TIMEOUT_EN is defined.
`ifdef BUS_TIMEOUT_EN
module bus_watchdog
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  // Count value seen during the last allowed access cycle
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] r_count;

  assign o_expire = i_count & (r_count == LP_LAST);

  // Access-cycle counter, cleared whenever the arbiter is idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 16'd0;
    end else if (i_clear) begin
      r_count <= 16'd0;
    end else if (i_count && !o_expire) begin
      r_count <= r_count + 16'd1;
    end else begin
      r_count <= r_count;
    end
  end

endmodule
`endif

// File: rtl/bus_arbiter.sv
// Two-requester arbiter sharing one external single-port bus between the
// fetch stage (IF) and the memory stage (MEM). Ties alternate via last_grant.
// Optional bus-ack watchdog enabled by the BUS_TIMEOUT_EN macro.
module bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_if_ready;
  logic        r_mem_ready;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic        w_if_pend;
  logic        w_mem_pend;
  logic        w_start_if;
  logic        w_start_mem;
  logic        w_if_done;
  logic        w_mem_done;
  logic        w_in_acc;
  logic        w_expire;
  logic [31:0] w_resp_data;

  if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  // A requester whose ready is high this cycle is finishing, not asking again
  assign w_if_pend   = bus.if_req & ~r_if_ready;
  assign w_mem_pend  = bus.mem_req & ~r_mem_ready;
  assign w_in_acc    = (r_state != ST_IDLE);
  // An ack wins over a simultaneous watchdog expiry
  assign w_resp_data = bus.bus_ack ? bus.bus_rdata : TIMEOUT_RDATA;

`ifdef BUS_TIMEOUT_EN
  logic r_bus_err;

  bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (~w_in_acc),
    .i_count  (w_in_acc),
    .o_expire (w_expire)
  );

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_err <= 1'b0;
    end else if (w_expire && !bus.bus_ack) begin
      r_bus_err <= 1'b1;
    end else begin
      r_bus_err <= r_bus_err;
    end
  end

  assign bus.bus_err = r_bus_err;
`else
  assign w_expire    = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant and completion decode
  always_comb begin
    w_state_nxt = r_state;
    w_start_if  = 1'b0;
    w_start_mem = 1'b0;
    w_if_done   = 1'b0;
    w_mem_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_pend && (!w_if_pend || (r_last_grant == GNT_IF))) begin
          w_start_mem = 1'b1;
          w_state_nxt = ST_MEM_ACC;
        end else if (w_if_pend) begin
          w_start_if  = 1'b1;
          w_state_nxt = ST_IF_ACC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IF_ACC: begin
        if (bus.bus_ack || w_expire) begin
          w_if_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_IF_ACC;
        end
      end
      ST_MEM_ACC: begin
        if (bus.bus_ack || w_expire) begin
          w_mem_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_MEM_ACC;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus command, response capture, ready pulses and grant history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= GNT_IF;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_sel    <= 4'h0;
      r_bus_addr   <= 32'h0;
      r_bus_wdata  <= 32'h0;
      r_if_rdata   <= 32'h0;
      r_mem_rdata  <= 32'h0;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
    end else begin
      r_if_ready  <= w_if_done;
      r_mem_ready <= w_mem_done;
      if (w_start_mem) begin
        r_last_grant <= GNT_MEM;
        r_bus_req    <= 1'b1;
        r_bus_we     <= bus.mem_we;
        r_bus_sel    <= bus.mem_sel;
        r_bus_addr   <= bus.mem_addr;
        r_bus_wdata  <= bus.mem_wdata;
      end else if (w_start_if) begin
        r_last_grant <= GNT_IF;
        r_bus_req    <= 1'b1;
        r_bus_we     <= 1'b0;
        r_bus_sel    <= 4'hF;
        r_bus_addr   <= bus.if_addr;
        r_bus_wdata  <= 32'h0;
      end else if (w_if_done || w_mem_done) begin
        r_bus_req    <= 1'b0;
      end else begin
        r_bus_req    <= r_bus_req;
      end
      if (w_if_done) begin
        r_if_rdata <= w_resp_data;
      end else begin
        r_if_rdata <= r_if_rdata;
      end
      if (w_mem_done) begin
        r_mem_rdata <= w_resp_data;
      end else begin
        r_mem_rdata <= r_mem_rdata;
      end
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_sel   = r_bus_sel;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_ready = r_mem_ready;
  assign bus.stall_if  = bus.if_req & ~r_if_ready;
  assign bus.stall_mem = bus.mem_req & ~r_mem_ready;

endmodule
